// File: rtl/ex_mem_stage.sv
// ============================================================================
// ex_mem_stage
// ----------------------------------------------------------------------------
// Execute-to-memory pipeline register of the RISC-V core.
//
// The stage captures the execute-stage result and the memory control for one
// instruction. At capture time it also works out three things:
//   - the store data shifted into its byte lanes,
//   - the byte strobes for the store,
//   - a flag that marks an access which is misaligned for its size.
// These are presented to the memory stage behind a valid/ready handshake.
// The output register also drives the EX-stage forwarding tap.
//
// Configuration macro: EX_MEM_SKID_EN
//   defined   : output register plus one skid register (two entries).
//               in_ready is registered (in_ready = ~skid_valid).
//   undefined : single output register.
//               in_ready = ~out_valid | out_ready (combinational).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   execute-side handshake
//   in_alu_res          ALU result, also the memory address
//   in_rs2_data         raw store data
//   in_rd, in_reg_wen   destination register and its writeback enable
//   in_mem_ren/wen      load / store enables
//   in_funct3           access size [1:0] (00 B, 01 H, 10 W); bit 2 = unsigned
//   in_pc               instruction PC, carried along for traps
//   flush               synchronous kill of every held beat
//   out_valid/out_ready memory-side handshake
//   out_*               registered beat (payload + pre-computed store info)
//   fwd_valid/rd/data   forwarding tap, combinational from the output register
// ============================================================================
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_rs2_data,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_wen,
    input  logic        in_mem_ren,
    input  logic        in_mem_wen,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_pc,

    input  logic        flush,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_alu_res,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic        out_reg_wen,
    output logic        out_mem_ren,
    output logic        out_mem_wen,
    output logic [2:0]  out_funct3,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_wstrb,
    output logic        out_misaligned,

    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data
);

    // ------------------------------------------------------------------------
    // One beat as it is held in the stage registers.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        reg_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [2:0]  funct3;
        logic [3:0]  wstrb;
        logic        misaligned;
    } beat_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // ------------------------------------------------------------------------
    // Capture-side pre-computation
    // ------------------------------------------------------------------------
    beat_t      in_beat;
    logic [1:0] off;
    logic [1:0] size;
    logic       mem_access;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // so no path leaves it unassigned; that is what keeps latches out.
    always_comb begin
        in_beat         = '0;
        off             = in_alu_res[1:0];
        size            = in_funct3[1:0];
        mem_access      = in_mem_ren | in_mem_wen;

        in_beat.alu_res = in_alu_res;
        in_beat.pc      = in_pc;
        in_beat.rd      = in_rd;
        in_beat.reg_wen = in_reg_wen;
        in_beat.mem_ren = in_mem_ren;
        in_beat.mem_wen = in_mem_wen;
        in_beat.funct3  = in_funct3;

        // Store data moves into the lanes selected by the low address bits.
        in_beat.wdata   = in_rs2_data << {off, 3'b000};

        // Size 11 is not a legal access size, so it is treated as misaligned
        // whenever memory is actually touched.
        unique case (size)
            SIZE_B:  in_beat.misaligned = 1'b0;
            SIZE_H:  in_beat.misaligned = mem_access & off[0];
            SIZE_W:  in_beat.misaligned = mem_access & (off != 2'b00);
            default: in_beat.misaligned = mem_access;
        endcase

        unique case (size)
            SIZE_B:  in_beat.wstrb = 4'b0001 << off;
            SIZE_H:  in_beat.wstrb = 4'b0011 << off;
            SIZE_W:  in_beat.wstrb = 4'b1111;
            default: in_beat.wstrb = 4'b0000;
        endcase

        // No strobes for non-stores, and none for a misaligned access: the
        // beat still travels on so the trap is raised downstream.
        if (!in_mem_wen || in_beat.misaligned) begin
            in_beat.wstrb = 4'b0000;
        end
    end

    // ------------------------------------------------------------------------
    // Storage and handshake
    // ------------------------------------------------------------------------
    logic  out_valid_q, out_valid_d;
    beat_t out_beat_q,  out_beat_d;
    logic  accept;

    assign accept = in_valid & in_ready;

`ifdef EX_MEM_SKID_EN
    logic  skid_valid_q, skid_valid_d;
    beat_t skid_beat_q,  skid_beat_d;

    // Registered: depends only on the skid flop, never on out_ready.
    assign in_ready = ~skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output slot is free after this edge. The skid beat is older than
            // anything on the input, so it goes first; while the skid is full
            // in_ready is 0 and no new beat can arrive in the same cycle.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_beat_d   = in_beat;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            // Output is stalled: park the new beat behind it.
            skid_valid_d = 1'b1;
            skid_beat_d  = in_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_beat_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_beat_q  <= skid_beat_d;
        end
    end
`else
    assign in_ready = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_ready) begin
            out_valid_d = accept;
            if (accept) begin
                out_beat_d = in_beat;
            end
        end
    end
`endif

    // NOTE: the payload registers are reset along with the valid bit because
    // every out_* port must read 0 while rst_n is low, not just out_valid.
    // NOTE: sequential state uses non-blocking assignment only, so all flops
    // sample their _d values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_beat_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_beat_q  <= out_beat_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid      = out_valid_q;
    assign out_alu_res    = out_beat_q.alu_res;
    assign out_pc         = out_beat_q.pc;
    assign out_rd         = out_beat_q.rd;
    assign out_reg_wen    = out_beat_q.reg_wen;
    assign out_mem_ren    = out_beat_q.mem_ren;
    assign out_mem_wen    = out_beat_q.mem_wen;
    assign out_funct3     = out_beat_q.funct3;
    assign out_wdata      = out_beat_q.wdata;
    assign out_wstrb      = out_beat_q.wstrb;
    assign out_misaligned = out_beat_q.misaligned;

    // Loads are excluded: their result is not known until the memory stage.
    assign fwd_valid = out_valid_q & out_beat_q.reg_wen & ~out_beat_q.mem_ren
                     & (out_beat_q.rd != 5'd0);
    assign fwd_rd    = out_beat_q.rd;
    assign fwd_data  = out_beat_q.alu_res;

endmodule
